// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// Every file of the arbiter imports this package.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  // Records which requester owns the RAM read that is currently in flight.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_ACC  = 2'd1,
    MEM_ACC = 2'd2
  } acc_state_e;

  function automatic logic at_limit(input int unsigned cnt, input int unsigned lim);
    return cnt >= lim;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Combinational winner pick between fetch and data requesters.
// The data side wins by default; fetch wins once it has starved long enough.
module arb_select
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = $clog2(STARVE_MAX_DEF + 1)
) (
  input  logic             if_req,
  input  logic             mem_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             gnt_if,
  output logic             gnt_mem
);

  logic starved;

  assign starved = at_limit(int'(starve_cnt), STARVE_MAX);

  always_comb begin
    gnt_if  = 1'b0;
    gnt_mem = 1'b0;
    if (if_req && (!mem_req || starved)) gnt_if  = 1'b1;
    else if (mem_req)                    gnt_mem = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data accesses.
// Grants are issued combinationally; read data returns one cycle later.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rd_en,
  output logic              ram_wr_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_if
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  acc_state_e       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             mem_wr_q;
  logic             sel_if;
  logic             sel_mem;

  arb_select #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_sel (
    .if_req     (if_req),
    .mem_req    (mem_req),
    .starve_cnt (starve_cnt),
    .gnt_if     (sel_if),
    .gnt_mem    (sel_mem)
  );

  // Reset masks grants in the same cycle so nothing reaches the RAM while held.
  assign if_gnt   = sel_if  & ~reset;
  assign mem_gnt  = sel_mem & ~reset;
  assign stall_if = if_req & ~if_gnt & ~reset;

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_rd_en = 1'b0;
    ram_wr_en = 1'b0;
    if (if_gnt) begin
      ram_addr  = if_addr;
      ram_rd_en = 1'b1;
    end else if (mem_gnt) begin
      ram_addr  = mem_addr;
      ram_rd_en = ~mem_we;
      ram_wr_en = mem_we;
      if (mem_we) ram_wdata = mem_wdata;
    end
  end

  // Next state depends only on this cycle's grant, allowing one access per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_wr_q   <= 1'b0;
    end else begin
      if (if_gnt)       state <= IF_ACC;
      else if (mem_gnt) state <= MEM_ACC;
      else              state <= IDLE;
      mem_wr_q <= mem_gnt & mem_we;
      if (if_gnt)
        starve_cnt <= '0;
      else if (if_req && starve_cnt != CNT_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // A reset arriving while an access is in flight suppresses its response.
  assign if_valid  = (state == IF_ACC)  & ~reset;
  assign mem_valid = (state == MEM_ACC) & ~reset;
  assign if_rdata  = if_valid ? ram_rdata : '0;
  assign mem_rdata = (mem_valid && !mem_wr_q) ? ram_rdata : '0;

endmodule
